shop_user_table: RTL and testbench
==================================

Name: shop_user_table

Overview:
- Parametrised user store for the shop database: holds up to MAX_USERS records of username, password and permission.
- Serves FIND, AUTH, ADD and DEL requests from the shop command FSM over an i_rdy/o_done handshake.
- Each request is a sequential one-entry-per-cycle scan with a fixed latency.
- Generalises the fixed admin-only login check: parametrised depth and string widths, a protected admin slot, and explicit status codes.

Parameters:
- NAME_CHARS, 3: username width in ASCII chars; NAME_BITS = NAME_CHARS*8.
- PASS_CHARS, 3: password width in ASCII chars; PASS_BITS = PASS_CHARS*8.
- MAX_USERS, 5: table depth including admin; legal range 2..16; IDX_BITS = $clog2(MAX_USERS), localparam.
- ADMIN_USERNAME, "Adm": slot-0 username loaded at reset.
- ADMIN_PASSWORD, "123": slot-0 password loaded at reset.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rdy  in  1  request strobe; sampled only in IDLE.
- i_op  in  2  operation: 0 FIND, 1 AUTH, 2 ADD, 3 DEL.
- i_name  in  NAME_BITS  username, right-aligned ASCII, zero-padded.
- i_pass  in  PASS_BITS  password; used by AUTH and ADD.
- i_perm  in  2  permission for ADD: 0 EMPTY, 1 ADMIN, 2 SELLER, 3 BUYER.
- o_busy  out  1  high from the accepting edge until o_done falls.
- o_done  out  1  one-cycle completion pulse.
- o_status  out  3  result: 0 OK, 1 NOT_FOUND, 2 BAD_PASS, 3 TAKEN, 4 FULL, 5 BAD_PERM, 6 PROTECTED, 7 reserved.
- o_idx  out  IDX_BITS  slot matched or written; 0 when not applicable.
- o_perm  out  2  permission of the matched slot; 0 otherwise.
- o_count  out  IDX_BITS+1  number of occupied slots.

Behaviour:
- Reset (async, any state):
  - Slot 0 = {ADMIN_USERNAME, ADMIN_PASSWORD, ADMIN}; all other slots perm=EMPTY, name/pass=0.
  - Outputs: o_busy=0, o_done=0, o_status=0, o_idx=0, o_perm=0, o_count=1.
  - State = IDLE. A reset mid-request aborts it with no done pulse.
- Slot occupancy is defined only by perm != EMPTY. Empty slots never match, including FIND with i_name=0.
- FSM states: IDLE, SCAN, COMMIT, DONE.
  - IDLE: when i_rdy=1 at an edge, latch i_op, i_name, i_pass and i_perm; go to SCAN with scan index 0; set o_busy=1.
  - SCAN: examine one slot per cycle, index 0..MAX_USERS-1. Record the first occupied slot whose name equals the latched name, and the first empty slot. After the last slot, go to COMMIT.
  - COMMIT: decide the status and perform any write (below). Register o_status, o_idx and o_perm. Go to DONE.
  - DONE: o_done=1 for exactly this cycle; next edge returns to IDLE and clears o_busy and o_done.
- Latency: o_done is high in the cycle beginning MAX_USERS+2 edges after the accepting edge, for every op.
- i_rdy while busy is ignored and never queued. A new request is accepted in the cycle after DONE at the earliest.
- o_status, o_idx and o_perm hold their values until the next COMMIT.
- FIND: match → OK, idx, perm. No match → NOT_FOUND.
- AUTH:
  - No name match → NOT_FOUND.
  - Name matches, password differs → BAD_PASS, idx, perm=0.
  - Both match → OK, idx, perm.
- ADD, priority order:
  - Name match → TAKEN, idx of the existing slot.
  - Else i_perm=EMPTY → BAD_PERM.
  - Else no empty slot → FULL.
  - Else write {name, pass, perm} into the lowest empty slot → OK, that idx; o_count +1 in COMMIT.
- DEL:
  - No match → NOT_FOUND.
  - Match at slot 0 → PROTECTED; table unchanged.
  - Otherwise set slot perm=EMPTY, name/pass=0 → OK, idx; o_count -1.
- Deleted slots are reused lowest-first. o_count never exceeds MAX_USERS and never goes below 1.
- Compares are full-width equality; no partial or case-insensitive match.

Test Plan:
- Reset, then AUTH "Adm"/"123" → o_done exactly 7 cycles after accept (MAX_USERS=5), status OK, idx 0, perm ADMIN, o_count 1.
- AUTH "Adm"/"Wpw" → BAD_PASS, idx 0. FIND "Uun" → NOT_FOUND. FIND with name 0 → NOT_FOUND.
- ADD "Us1"/"Ps1"/SELLER → OK idx 1, then ADD "Ub1"/"Pb1"/BUYER → OK idx 2, o_count 3. Repeat ADD "Us1" → TAKEN idx 1. ADD "Uq1"/EMPTY → BAD_PERM.
- Fill to 5 users, then ADD "Ux9"/BUYER → FULL, o_count 5. DEL "Ub1" → OK idx 2, o_count 4. ADD "Ux9"/BUYER → OK idx 2 (slot reuse).
- DEL "Adm" → PROTECTED, table unchanged. Pulse i_rdy during SCAN → ignored, exactly one o_done.
- Assert i_reset_n=0 mid-SCAN of an ADD → no o_done, o_count 1. After release, FIND "Us1" → NOT_FOUND and AUTH admin → OK.

Source files
------------

// File: rtl/shop_user_table.sv
// User store for the shop database: serves FIND/AUTH/ADD/DEL requests
// by scanning one slot per cycle, then committing the result.
module shop_user_table #(
  parameter int NAME_CHARS = 3,
  parameter int PASS_CHARS = 3,
  parameter int MAX_USERS  = 5,
  parameter logic [NAME_CHARS*8-1:0] ADMIN_USERNAME = "Adm",
  parameter logic [PASS_CHARS*8-1:0] ADMIN_PASSWORD = "123",
  localparam int NAME_BITS = NAME_CHARS*8,
  localparam int PASS_BITS = PASS_CHARS*8,
  localparam int IDX_BITS  = $clog2(MAX_USERS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_rdy,
  input  logic [1:0]           i_op,
  input  logic [NAME_BITS-1:0] i_name,
  input  logic [PASS_BITS-1:0] i_pass,
  input  logic [1:0]           i_perm,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2:0]           o_status,
  output logic [IDX_BITS-1:0]  o_idx,
  output logic [1:0]           o_perm,
  output logic [IDX_BITS:0]    o_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_DONE} state_e;

  localparam logic [1:0] OP_FIND = 2'd0, OP_AUTH = 2'd1, OP_ADD = 2'd2, OP_DEL = 2'd3;
  localparam logic [1:0] PERM_EMPTY = 2'd0, PERM_ADMIN = 2'd1;
  localparam logic [2:0] ST_OK = 3'd0, ST_NOT_FOUND = 3'd1, ST_BAD_PASS = 3'd2,
                         ST_TAKEN = 3'd3, ST_FULL = 3'd4, ST_BAD_PERM = 3'd5,
                         ST_PROTECTED = 3'd6;
  localparam logic [IDX_BITS:0] SCAN_END = (IDX_BITS+1)'(MAX_USERS);

  state_e state_q, state_d;

  logic [NAME_BITS-1:0] tbl_name_q [MAX_USERS];
  logic [PASS_BITS-1:0] tbl_pass_q [MAX_USERS];
  logic [1:0]           tbl_perm_q [MAX_USERS];
  logic [IDX_BITS:0]    count_q;

  logic [1:0]           req_op_q, req_perm_q;
  logic [NAME_BITS-1:0] req_name_q;
  logic [PASS_BITS-1:0] req_pass_q;

  // Slot reads are registered; the compare runs one cycle behind the scan index.
  logic [IDX_BITS:0]    scan_q;
  logic                 rd_vld_q;
  logic [IDX_BITS-1:0]  rd_idx_q;
  logic [NAME_BITS-1:0] rd_name_q;
  logic [PASS_BITS-1:0] rd_pass_q;
  logic [1:0]           rd_perm_q;

  logic                 hit_q, hit_pass_ok_q, free_q;
  logic [IDX_BITS-1:0]  hit_idx_q, free_idx_q;
  logic [1:0]           hit_perm_q;

  logic [2:0]           status_q, status_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [1:0]           perm_q, perm_d;
  logic                 add_we, del_we;
  logic                 rd_occ, rd_match;

  assign rd_occ   = rd_vld_q && (rd_perm_q != PERM_EMPTY);
  assign rd_match = rd_occ && (rd_name_q == req_name_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_rdy) state_d = S_SCAN;
      S_SCAN:   if (scan_q == SCAN_END) state_d = S_COMMIT;
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Result decision from the recorded scan outcome, in priority order.
  always_comb begin
    status_d = ST_OK;
    idx_d    = '0;
    perm_d   = PERM_EMPTY;
    add_we   = 1'b0;
    del_we   = 1'b0;
    case (req_op_q)
      OP_FIND: begin
        if (!hit_q) status_d = ST_NOT_FOUND;
        else begin idx_d = hit_idx_q; perm_d = hit_perm_q; end
      end
      OP_AUTH: begin
        if (!hit_q) status_d = ST_NOT_FOUND;
        else if (!hit_pass_ok_q) begin status_d = ST_BAD_PASS; idx_d = hit_idx_q; end
        else begin idx_d = hit_idx_q; perm_d = hit_perm_q; end
      end
      OP_ADD: begin
        if (hit_q) begin status_d = ST_TAKEN; idx_d = hit_idx_q; end
        else if (req_perm_q == PERM_EMPTY) status_d = ST_BAD_PERM;
        else if (!free_q) status_d = ST_FULL;
        else begin idx_d = free_idx_q; add_we = 1'b1; end
      end
      default: begin
        if (!hit_q) status_d = ST_NOT_FOUND;
        else if (hit_idx_q == '0) status_d = ST_PROTECTED;
        else begin idx_d = hit_idx_q; del_we = 1'b1; end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      req_op_q <= '0; req_perm_q <= '0; req_name_q <= '0; req_pass_q <= '0;
      scan_q <= '0; rd_vld_q <= 1'b0; rd_idx_q <= '0;
      rd_name_q <= '0; rd_pass_q <= '0; rd_perm_q <= '0;
      hit_q <= 1'b0; hit_pass_ok_q <= 1'b0; hit_idx_q <= '0; hit_perm_q <= '0;
      free_q <= 1'b0; free_idx_q <= '0;
      status_q <= '0; idx_q <= '0; perm_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (i_rdy) begin
          req_op_q <= i_op; req_name_q <= i_name;
          req_pass_q <= i_pass; req_perm_q <= i_perm;
          scan_q <= '0; rd_vld_q <= 1'b0;
          hit_q <= 1'b0; free_q <= 1'b0;
        end
        S_SCAN: begin
          scan_q   <= scan_q + 1'b1;
          rd_vld_q <= (scan_q != SCAN_END);
          if (scan_q != SCAN_END) begin
            rd_idx_q  <= scan_q[IDX_BITS-1:0];
            rd_name_q <= tbl_name_q[scan_q[IDX_BITS-1:0]];
            rd_pass_q <= tbl_pass_q[scan_q[IDX_BITS-1:0]];
            rd_perm_q <= tbl_perm_q[scan_q[IDX_BITS-1:0]];
          end
          if (rd_match && !hit_q) begin
            hit_q         <= 1'b1;
            hit_idx_q     <= rd_idx_q;
            hit_perm_q    <= rd_perm_q;
            hit_pass_ok_q <= (rd_pass_q == req_pass_q);
          end
          if (rd_vld_q && !rd_occ && !free_q) begin
            free_q     <= 1'b1;
            free_idx_q <= rd_idx_q;
          end
        end
        S_COMMIT: begin
          status_q <= status_d;
          idx_q    <= idx_d;
          perm_q   <= perm_d;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tbl_name_q[0] <= ADMIN_USERNAME;
      tbl_pass_q[0] <= ADMIN_PASSWORD;
      tbl_perm_q[0] <= PERM_ADMIN;
      for (int i = 1; i < MAX_USERS; i++) begin
        tbl_name_q[i] <= '0;
        tbl_pass_q[i] <= '0;
        tbl_perm_q[i] <= PERM_EMPTY;
      end
      count_q <= (IDX_BITS+1)'(1);
    end else if (state_q == S_COMMIT) begin
      if (add_we) begin
        tbl_name_q[free_idx_q] <= req_name_q;
        tbl_pass_q[free_idx_q] <= req_pass_q;
        tbl_perm_q[free_idx_q] <= req_perm_q;
        count_q <= count_q + 1'b1;
      end else if (del_we) begin
        tbl_name_q[hit_idx_q] <= '0;
        tbl_pass_q[hit_idx_q] <= '0;
        tbl_perm_q[hit_idx_q] <= PERM_EMPTY;
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_DONE);
  assign o_status = status_q;
  assign o_idx    = idx_q;
  assign o_perm   = perm_q;
  assign o_count  = count_q;

endmodule

// File: tb/tb_shop_user_table.sv
// Scoreboard bench for shop_user_table: a reference table model predicts each
// result at issue time; a monitor compares it when o_done pulses.
module tb_shop_user_table;
  localparam int MAXU = 5;

  logic        i_clk = 1'b0, i_reset_n = 1'b0, i_rdy = 1'b0;
  logic [1:0]  i_op = '0, i_perm = '0;
  logic [23:0] i_name = '0, i_pass = '0;
  logic        o_busy, o_done;
  logic [2:0]  o_status, o_idx;
  logic [1:0]  o_perm;
  logic [3:0]  o_count;

  shop_user_table #(.MAX_USERS(MAXU)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rdy(i_rdy), .i_op(i_op),
    .i_name(i_name), .i_pass(i_pass), .i_perm(i_perm),
    .o_busy(o_busy), .o_done(o_done), .o_status(o_status), .o_idx(o_idx),
    .o_perm(o_perm), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {int st; int idx; int perm; bit chk_perm; int cnt; int acc;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [23:0] m_name [MAXU];
  logic [23:0] m_pass [MAXU];
  int          m_perm [MAXU];
  int          m_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAXU; i++) begin m_name[i] = '0; m_pass[i] = '0; m_perm[i] = 0; end
    m_name[0] = "Adm"; m_pass[0] = "123"; m_perm[0] = 1; m_cnt = 1;
  endtask

  task automatic model_op(input int op, input logic [23:0] nm, input logic [23:0] pw,
                          input int pm, output exp_t e);
    int hit, fr;
    hit = -1; fr = -1;
    for (int i = 0; i < MAXU; i++) begin
      if (m_perm[i] != 0 && m_name[i] == nm && hit < 0) hit = i;
      if (m_perm[i] == 0 && fr < 0) fr = i;
    end
    e.st = 0; e.idx = 0; e.perm = 0; e.chk_perm = (op < 2); e.acc = 0;
    case (op)
      0: if (hit < 0) e.st = 1; else begin e.idx = hit; e.perm = m_perm[hit]; end
      1: if (hit < 0) e.st = 1;
         else if (m_pass[hit] != pw) begin e.st = 2; e.idx = hit; end
         else begin e.idx = hit; e.perm = m_perm[hit]; end
      2: if (hit >= 0) begin e.st = 3; e.idx = hit; end
         else if (pm == 0) e.st = 5;
         else if (fr < 0) e.st = 4;
         else begin
           m_name[fr] = nm; m_pass[fr] = pw; m_perm[fr] = pm; m_cnt++; e.idx = fr;
         end
      default: if (hit < 0) e.st = 1;
         else if (hit == 0) e.st = 6;
         else begin
           m_name[hit] = '0; m_pass[hit] = '0; m_perm[hit] = 0; m_cnt--; e.idx = hit;
         end
    endcase
    e.cnt = m_cnt;
  endtask

  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_reset_n && o_done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("status", int'(o_status), e.st);
        chk("idx", int'(o_idx), e.idx);
        if (e.chk_perm) chk("perm", int'(o_perm), e.perm);
        chk("count", int'(o_count), e.cnt);
        chk("latency", cyc - e.acc, MAXU + 2);
      end
    end
  end

  task automatic req(input int op, input logic [23:0] nm, input logic [23:0] pw,
                     input int pm, input bit glitch = 1'b0);
    exp_t e;
    @(negedge i_clk);
    model_op(op, nm, pw, pm, e);
    e.acc = cyc + 1;
    sb.push_back(e);
    i_op = 2'(op); i_name = nm; i_pass = pw; i_perm = 2'(pm); i_rdy = 1'b1;
    @(negedge i_clk);
    i_rdy = 1'b0;
    chk("busy_after_accept", int'(o_busy), 1);
    if (glitch) begin
      repeat (2) @(negedge i_clk);
      i_op = 2'd2; i_name = "Ugl"; i_perm = 2'd3; i_rdy = 1'b1;
      @(negedge i_clk);
      i_rdy = 1'b0;
    end
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin @(negedge i_clk); #1; end
    if (sb.size() != 0) begin chk("done_timeout", sb.size(), 0); sb.delete(); end
    if (glitch) begin
      repeat (12) @(negedge i_clk);
      chk("busy_after_glitch", int'(o_busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge i_clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_status", int'(o_status), 0);
    chk("rst_idx", int'(o_idx), 0);
    chk("rst_perm", int'(o_perm), 0);
    chk("rst_count", int'(o_count), 1);
    i_reset_n = 1'b1;

    req(1, "Adm", "123", 0);
    req(1, "Adm", "Wpw", 0);
    req(0, "Uun", 0, 0);
    req(0, 24'd0, 0, 0);
    req(0, "adm", 0, 0);
    req(2, "Us1", "Ps1", 2);
    req(2, "Ub1", "Pb1", 3);
    req(2, "Us1", "Zzz", 3);
    req(2, "Uq1", "Pq1", 0);
    req(2, "Uc3", "Pc3", 3);
    req(2, "Ud4", "Pd4", 2);
    req(2, "Ux9", "Px9", 3);
    req(3, "Ub1", 0, 0);
    req(2, "Ux9", "Px9", 3);
    req(0, "Ux9", 0, 0);
    req(1, "Us1", "Ps1", 0);
    req(3, "Adm", 0, 0);
    req(1, "Adm", "123", 0);
    req(0, "Us1", 0, 0, 1'b1);

    // Abort an ADD mid-scan; no completion may follow.
    @(negedge i_clk);
    i_op = 2'd2; i_name = "Uz1"; i_pass = "Pz1"; i_perm = 2'd3; i_rdy = 1'b1;
    @(negedge i_clk);
    i_rdy = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_count", int'(o_count), 1);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_reset();
    repeat (12) @(negedge i_clk);
    chk("abort_idle", int'(o_busy), 0);

    req(0, "Us1", 0, 0);
    req(1, "Adm", "123", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
